dot_product_16: RTL and testbench

DOT_PRODUCT_16 -- requirements
Module: dot_product_16

---
 rtl/dot_product_16.sv | 136 +++++++++++++
 tb/tb_dot_product_16.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dot_product_16.sv
// dot_product_16: streaming unsigned dot product of up to 255 pairs of 16-bit operands.
// Also contains karatsuba_16, the combinational 16x16 -> 32 unsigned multiplier.
//
// dot_product_16 ports:
//   clk, rst_n           clock; asynchronous active-low reset
//   start, len           begin a job of len operand pairs (sampled only in IDLE)
//   in_valid, in_ready   operand pair handshake; a, b are the operands
//   out_valid, out_ready result handshake
//   result               sum of products, modulo 2^ACC_W
//   overflow             sticky carry-out of the accumulator for the current job
//   busy                 job in progress (ACC or DONE)

module karatsuba_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);
    logic [7:0]  ah, al, bh, bl;
    logic [8:0]  as, bs;
    logic [15:0] z2, z0;
    logic [17:0] zm, z1;

    assign ah = a[15:8];
    assign al = a[7:0];
    assign bh = b[15:8];
    assign bl = b[7:0];
    assign as = {1'b0, ah} + {1'b0, al};
    assign bs = {1'b0, bh} + {1'b0, bl};

    assign z2 = 16'(ah) * 16'(bh);
    assign z0 = 16'(al) * 16'(bl);
    assign zm = 18'(as) * 18'(bs);
    // Middle term ah*bl + al*bh, never negative and at most 17 bits.
    assign z1 = zm - 18'(z2) - 18'(z0);

    assign p = {z2, 16'b0} + {6'b0, z1, 8'b0} + {16'b0, z0};
endmodule

module dot_product_16 #(
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      a,
    input  logic [15:0]      b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             overflow,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t           state, state_nxt;
    logic [7:0]       len_q;
    logic [7:0]       count;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [31:0]      prod;
    logic [ACC_W:0]   sum;
    logic             accept;
    logic             last_beat;

    karatsuba_16 u_mul (
        .a (a),
        .b (b),
        .p (prod)
    );

    // One extra bit on the adder captures the carry out of the accumulator.
    assign sum       = {1'b0, acc} + {{(ACC_W + 1 - 32){1'b0}}, prod};
    assign accept    = in_valid && (state == ACC);
    assign last_beat = accept && ((count + 8'd1) == len_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (len == 8'd0) ? DONE : ACC;
            ACC:  if (last_beat) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ACC: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath. acc is not cleared on job completion, so result keeps the
    // last job's value through IDLE until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= 8'd0;
            count <= 8'd0;
            acc   <= '0;
            ovf   <= 1'b0;
        end else if (state == IDLE && start) begin
            len_q <= len;
            count <= 8'd0;
            acc   <= '0;
            ovf   <= 1'b0;
        end else if (accept) begin
            acc   <= sum[ACC_W-1:0];
            count <= count + 8'd1;
            if (sum[ACC_W]) ovf <= 1'b1;
        end
    end

    assign result   = acc;
    assign overflow = ovf;
endmodule

// File: tb/tb_dot_product_16.sv
module tb_dot_product_16;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [15:0] a, b;
    logic        out_ready;

    logic        in_ready40, out_valid40, ovf40, busy40;
    logic [39:0] res40;
    logic        in_ready32, out_valid32, ovf32, busy32;
    logic [31:0] res32;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dot_product_16 #(.ACC_W(40)) u40 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready40), .a(a), .b(b),
        .out_valid(out_valid40), .out_ready(out_ready), .result(res40),
        .overflow(ovf40), .busy(busy40)
    );

    dot_product_16 #(.ACC_W(32)) u32 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready32), .a(a), .b(b),
        .out_valid(out_valid32), .out_ready(out_ready), .result(res32),
        .overflow(ovf32), .busy(busy32)
    );

    typedef struct {
        int               n;
        logic [3:0][15:0] va;
        logic [3:0][15:0] vb;
        int               bubble_after;   // insert one idle cycle after this beat (0 = none)
        logic [39:0]      exp40;
        logic             eovf40;
        logic [31:0]      exp32;
        logic             eovf32;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_job(input vec_t v);
        @(negedge clk);
        start = 1'b1; len = 8'(v.n); in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; len = 8'hFF;   // a later len change must not matter
        check("busy_in_acc", 64'(busy40), 64'd1);
        for (int i = 0; i < v.n; i++) begin
            in_valid = 1'b1; a = v.va[i]; b = v.vb[i];
            check("in_ready_beat", 64'({in_ready40, in_ready32}), 64'd3);
            @(negedge clk);
            if (v.bubble_after == i + 1 && i + 1 < v.n) begin
                in_valid = 1'b0; a = 16'hFFFF; b = 16'hFFFF;
                check("in_ready_bubble", 64'(in_ready40), 64'd1);
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        check("out_valid_latency", 64'({out_valid40, out_valid32}), 64'd3);
        check("in_ready_after_last", 64'({in_ready40, in_ready32}), 64'd0);
        check("result40", 64'(res40), 64'(v.exp40));
        check("ovf40", 64'(ovf40), 64'(v.eovf40));
        check("result32", 64'(res32), 64'(v.exp32));
        check("ovf32", 64'(ovf32), 64'(v.eovf32));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_out_valid", 64'({out_valid40, busy40}), 64'd0);
        check("idle_result_hold", 64'(res40), 64'(v.exp40));
    endtask

    vec_t vecs[5];
    vec_t v81;

    initial begin
        vecs[0] = '{3, {16'd0, 16'd7, 16'd5, 16'd3}, {16'd0, 16'd8, 16'd6, 16'd4}, 0,
                    40'd98, 1'b0, 32'd98, 1'b0};
        vecs[1] = '{2, {16'd0, 16'd0, 16'h0002, 16'hFFFF}, {16'd0, 16'd0, 16'h0001, 16'hFFFF}, 0,
                    40'hFFFE0003, 1'b0, 32'hFFFE0003, 1'b0};
        vecs[2] = '{2, {16'd0, 16'd0, 16'hFFFF, 16'hFFFF}, {16'd0, 16'd0, 16'hFFFF, 16'hFFFF}, 1,
                    40'h1FFFC0002, 1'b0, 32'hFFFC0002, 1'b1};
        vecs[3] = '{4, {16'hABCD, 16'd100, 16'd3, 16'd1}, {16'h1234, 16'd200, 16'd4, 16'd2}, 2,
                    40'd204971474, 1'b0, 32'd204971474, 1'b0};
        vecs[4] = '{2, {16'd0, 16'd0, 16'hFF00, 16'h8000}, {16'd0, 16'd0, 16'h00FF, 16'h8000}, 0,
                    40'd1090388224, 1'b0, 32'd1090388224, 1'b0};
        v81     = '{1, {16'd0, 16'd0, 16'd0, 16'd9}, {16'd0, 16'd0, 16'd0, 16'd9}, 0,
                    40'd81, 1'b0, 32'd81, 1'b0};

        rst_n = 1'b0; start = 1'b0; len = 8'd0; in_valid = 1'b0;
        a = 16'd0; b = 16'd0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 64'({in_ready40, out_valid40, ovf40, busy40}), 64'd0);
        check("reset_result", 64'(res40), 64'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_job(vecs[i]);

        // len = 0: straight to DONE, result 0, overflow cleared, stable while stalled
        @(negedge clk);
        start = 1'b1; len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("len0_out_valid", 64'({out_valid40, out_valid32}), 64'd3);
            check("len0_in_ready", 64'({in_ready40, in_ready32}), 64'd0);
            check("len0_result", 64'({res40, res32}), 64'd0);
            check("len0_ovf32", 64'(ovf32), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("len0_idle", 64'({out_valid40, busy40}), 64'd0);

        // start with len=7 during ACC and DONE is ignored; DONE exits in one
        // cycle when out_ready is already high, ignoring start in that cycle
        @(negedge clk);
        start = 1'b1; len = 8'd2;
        @(negedge clk);
        len = 8'd7; in_valid = 1'b1; a = 16'd1; b = 16'd1;
        @(negedge clk);
        a = 16'd2; b = 16'd2;
        @(negedge clk);
        in_valid = 1'b0;
        check("ign_done", 64'(out_valid40), 64'd1);
        check("ign_result", 64'(res40), 64'd5);
        @(negedge clk);
        check("ign_stall", 64'({out_valid40, in_ready40}), 64'd2);
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b0;
        check("ign_idle", 64'({busy40, in_ready40, out_valid40}), 64'd0);
        @(negedge clk);
        check("ign_stays_idle", 64'(busy40), 64'd0);

        // reset mid-job abandons it immediately
        @(negedge clk);
        start = 1'b1; len = 8'd4;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; a = 16'd5; b = 16'd5;
        @(negedge clk);
        a = 16'd6; b = 16'd6;
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_reset_busy", 64'(busy40), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midreset_ctl", 64'({in_ready40, out_valid40, ovf40, busy40}), 64'd0);
        check("midreset_result", 64'({res40, res32}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", 64'(busy40), 64'd0);
        run_job(v81);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
